// File: rtl/bcd_to_grey4_df.sv
// bcd_to_grey4_df: registered BCD-to-Gray converter with DIGITS independent 4-bit lanes.
//
// Each lane k takes d = bcd[4k+3:4k] and produces g = d ^ (d >> 1).
// Codes 10-15 use the same rule and are not zeroed.
// Latency is one cycle. grey and err only change on accepted samples (in_valid=1).
//
// Ports:
//   clk       in   1         rising-edge clock
//   rst_n     in   1         asynchronous active-low reset
//   in_valid  in   1         bcd is sampled when high
//   bcd       in   4*DIGITS  packed digits; lane k at [4k+3:4k]
//   grey      out  4*DIGITS  packed Gray codes, same lane layout as bcd
//   out_valid out  1         one-cycle strobe marking a fresh grey
//   err       out  1         some sampled digit was > 9
//
// Optional feature, macro BCD_CHECK_EN:
//   When defined, err is registered with grey and holds with it.
//   When undefined, err is tied to 0 and no comparators are built.

module bcd_to_grey4_df #(
  parameter int unsigned DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS-1:0]   grey,
  output logic                  out_valid,
  output logic                  err
);

  localparam int unsigned LANE_W = 4;
  localparam int unsigned W      = LANE_W * DIGITS;

  logic [W-1:0] grey_nxt_c;

  // Per-lane reflected-binary conversion; lanes never interact.
  always_comb begin
    grey_nxt_c = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      grey_nxt_c[k*LANE_W +: LANE_W] =
        bcd[k*LANE_W +: LANE_W] ^ (bcd[k*LANE_W +: LANE_W] >> 1);
    end
  end

  // Result register: load on accepted sample, otherwise hold. The strobe drops when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grey      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        grey <= grey_nxt_c;
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic bad_c;
  logic err_q;

  // Flag any lane whose digit falls outside the decimal range 0..9.
  always_comb begin
    bad_c = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd[k*LANE_W +: LANE_W] > LANE_W'(9)) begin
        bad_c = 1'b1;
      end
    end
  end

  // err follows the same load/hold rule as grey.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_valid) begin
      err_q <= bad_c;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_grey4_df.sv
module tb_bcd_to_grey4_df;

  logic       clk;
  logic       rst_n;
  logic       v1, v2;
  logic [3:0] b1;
  logic [7:0] b2;
  logic [3:0] g1;
  logic [7:0] g2;
  logic       ov1, ov2, e1, e2;

  int checks   = 0;
  int failures = 0;

`ifdef BCD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Reference model state.
  logic [3:0] gtab [16];
  logic [3:0] x_g1;
  logic [7:0] x_g2;
  logic       x_v1, x_v2, x_e1, x_e2;

  bcd_to_grey4_df #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .bcd(b1),
    .grey(g1), .out_valid(ov1), .err(e1)
  );

  bcd_to_grey4_df #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .bcd(b2),
    .grey(g2), .out_valid(ov2), .err(e2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Build the reflected Gray sequence by mirroring: the upper half is the
  // lower half in reverse order with the new top bit set.
  task automatic build_gray_table();
    gtab[0] = 4'd0;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < (1 << n); i++) begin
        gtab[(2 << n) - 1 - i] = gtab[i] | 4'(1 << n);
      end
    end
  endtask

  task automatic model_reset();
    x_g1 = '0; x_g2 = '0;
    x_v1 = 1'b0; x_v2 = 1'b0;
    x_e1 = 1'b0; x_e2 = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".g1"},  {4'h0, g1}, {4'h0, x_g1});
    check({tag, ".ov1"}, {7'h0, ov1}, {7'h0, x_v1});
    check({tag, ".e1"},  {7'h0, e1}, {7'h0, x_e1});
    check({tag, ".g2"},  g2, x_g2);
    check({tag, ".ov2"}, {7'h0, ov2}, {7'h0, x_v2});
    check({tag, ".e2"},  {7'h0, e2}, {7'h0, x_e2});
  endtask

  // One clock: the model captures the current inputs, then outputs are compared.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    x_v1 = v1;
    if (v1) begin
      x_g1 = gtab[b1];
      x_e1 = CHK && (b1 > 4'd9);
    end
    x_v2 = v2;
    if (v2) begin
      x_g2 = {gtab[b2[7:4]], gtab[b2[3:0]]};
      x_e2 = CHK && ((b2[7:4] > 4'd9) || (b2[3:0] > 4'd9));
    end
    check_all(tag);
  endtask

  initial begin
    build_gray_table();
    model_reset();
    rst_n = 1'b0;
    v1 = 1'b0; v2 = 1'b0; b1 = '0; b2 = '0;
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Spec examples, checked against literal values.
    b1 = 4'b0101; v1 = 1'b1; b2 = 8'h59; v2 = 1'b1;
    step("ex1");
    check("lit_0101", {4'h0, g1}, 8'h07);
    check("lit_59", g2, 8'h7D);
    b1 = 4'b1111; v1 = 1'b0; b2 = 8'h90;
    step("hold");
    check("lit_hold", {4'h0, g1}, 8'h07);
    check("lit_hold_ov", {7'h0, ov1}, 8'h00);
    check("lit_90", g2, 8'hD0);
    b2 = 8'h3A; v2 = 1'b1;
    step("ex3A");
    check("lit_3A", g2, 8'h2F);
    check("lit_3A_err", {7'h0, e2}, {7'h0, CHK});
    b2 = 8'h42;
    step("ex42");
    check("lit_42", g2, 8'h63);
    check("lit_42_err", {7'h0, e2}, 8'h00);

    // Walk every 4-bit code back to back.
    v1 = 1'b1;
    for (int d = 0; d < 16; d++) begin
      b1 = 4'(d);
      b2 = {4'(15 - d), 4'(d)};
      step("walk");
    end
    check("lit_1111", {4'h0, g1}, 8'h08);

    // Asynchronous reset between edges, after a nonzero result.
    b1 = 4'b0101; v1 = 1'b1; b2 = 8'hF7; v2 = 1'b1;
    step("pre_rst");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    v1 = 1'b0; v2 = 1'b0;
    #2 rst_n = 1'b1;
    step("post_rst");

    // Reset mid-stream with in_valid held high.
    b1 = 4'd9; b2 = 8'hAB; v1 = 1'b1; v2 = 1'b1;
    step("stream");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    v1 = 1'b0; v2 = 1'b0;
    #2 rst_n = 1'b1;
    step("mid_rel");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      v1 = 1'($urandom_range(0, 3) != 0);
      v2 = 1'($urandom_range(0, 3) != 0);
      b1 = 4'($urandom);
      b2 = 8'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
